// File: rtl/sar_adc_scan.sv
// sar_adc_scan: multi-channel successive-approximation ADC controller.
// Drives the analog mux select and the R-2R DAC code, and reads the external
// comparator once per bit. It supports single-shot conversions and a continuous
// round-robin scan. Each result is passed on through a one-entry valid/ready
// output register.
module sar_adc_scan #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SETTLE = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CH_W-1:0]  ch_i,
    input  logic             cont_i,
    input  logic             comp_i,
    output logic [WIDTH-1:0] dac_o,
    output logic [CH_W-1:0]  mux_sel_o,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic [CH_W-1:0]  res_ch_o
);

    // The settle counter only has to hold SETTLE-1.
    localparam int              CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK   = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
    // One extra bit lets NUM_CH be compared against any ch_i value without overflow.
    localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  mux_sel_q, mux_sel_d;
    logic [CH_W-1:0]  scan_q, scan_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [CH_W-1:0]  res_ch_q, res_ch_d;

    logic             accept;
    logic [CH_W-1:0]  acc_ch;
    logic             load;

    // Next channel of the round-robin scan. It wraps after the last valid channel,
    // not at the power of two.
    function automatic logic [CH_W-1:0] next_scan(input logic [CH_W-1:0] ch);
        return (ch == LAST_CH) ? '0 : ch + 1'b1;
    endfunction

    // Keep the trial bit when the input is at or above the trial DAC voltage.
    function automatic logic [WIDTH-1:0] decide_bit(input logic [WIDTH-1:0] res,
                                                    input logic [WIDTH-1:0] mask,
                                                    input logic             comp);
        return comp ? (res | mask) : res;
    endfunction

    // A single-shot request is valid only for a channel that exists.
    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        return {1'b0, ch} < NUM_CH_EXT;
    endfunction

    // Next-state logic for the FSM, the SAR datapath and the output register.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        mux_sel_d   = mux_sel_q;
        scan_d      = scan_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ch_d    = res_ch_q;
        accept      = 1'b0;
        acc_ch      = '0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Continuous scan wins over a single-shot request.
                if (cont_i) begin
                    accept = 1'b1;
                    acc_ch = scan_q;
                    scan_d = next_scan(scan_q);
                end else if (start_i && ch_in_range(ch_i)) begin
                    accept = 1'b1;
                    acc_ch = ch_i;
                end
                if (accept) begin
                    mux_sel_d = acc_ch;
                    mask_d    = MSB_MASK;
                    result_d  = '0;
                    cnt_d     = CNT_RELOAD;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // The last settle cycle of the bit: sample the comparator and move on.
                    result_d = decide_bit(result_q, mask_q, comp_i);
                    mask_d   = mask_q >> 1;
                    cnt_d    = CNT_RELOAD;
                    if (mask_q[0]) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Hand off only when the output slot is free or is being drained this cycle.
                if (!res_valid_q || res_ready_i) begin
                    load    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            res_data_d  = result_q;
            res_ch_d    = mux_sel_q;
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers. A reset clears everything, including any buffered result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q      <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            mux_sel_q   <= '0;
            scan_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
        end else begin
            mask_q      <= mask_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            mux_sel_q   <= mux_sel_d;
            scan_q      <= scan_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
        end
    end

    // While converting, the DAC shows the trial code. In DONE and IDLE mask_q is zero,
    // so the DAC holds the final code.
    assign dac_o       = result_q | mask_q;
    assign mux_sel_o   = mux_sel_q;
    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_ch_o    = res_ch_q;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Directed bench for sar_adc_scan: a 4-channel instance and a 3-channel instance,
// each with an ideal comparator model fed from a per-channel input table.
module tb_sar_adc_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel instance
    logic       start = 1'b0, cont = 1'b0, ready = 1'b0;
    logic [1:0] ch = '0;
    logic       comp;
    logic [7:0] dac, rdata;
    logic [1:0] msel, rch;
    logic       busy, rvalid;
    logic [7:0] vin_tab [4];

    assign comp = (vin_tab[msel] >= dac);

    sar_adc_scan #(.WIDTH(8), .NUM_CH(4), .SETTLE(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ch_i(ch), .cont_i(cont),
        .comp_i(comp), .dac_o(dac), .mux_sel_o(msel), .busy_o(busy),
        .res_valid_o(rvalid), .res_ready_i(ready), .res_data_o(rdata), .res_ch_o(rch)
    );

    // 3-channel instance
    logic       start3 = 1'b0, cont3 = 1'b0, ready3 = 1'b0;
    logic [1:0] ch3 = '0;
    logic       comp3;
    logic [7:0] dac3, rdata3;
    logic [1:0] msel3, rch3;
    logic       busy3, rvalid3;
    logic [7:0] vin3_tab [4];

    assign comp3 = (vin3_tab[msel3] >= dac3);

    sar_adc_scan #(.WIDTH(8), .NUM_CH(3), .SETTLE(2)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .ch_i(ch3), .cont_i(cont3),
        .comp_i(comp3), .dac_o(dac3), .mux_sel_o(msel3), .busy_o(busy3),
        .res_valid_o(rvalid3), .res_ready_i(ready3), .res_data_o(rdata3), .res_ch_o(rch3)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-shot conversion on the 4-channel instance, started in the current cycle T,
    // with ready held low. The result is drained at the end.
    task automatic run_single(input string tag, input logic [1:0] c, input logic [7:0] exp,
                              input logic [7:0] dac_t1, input logic [7:0] dac_t3);
        start = 1'b1;
        ch    = c;
        step();                                   // T+1
        start = 1'b0;
        chk({tag, ".mux"},  msel, c);
        chk({tag, ".busy1"}, busy, 1);
        chk({tag, ".dac1"},  dac, dac_t1);
        step(2);                                  // T+3
        chk({tag, ".dac3"},  dac, dac_t3);
        step(14);                                 // T+17
        chk({tag, ".busy17"}, busy, 1);
        chk({tag, ".vld17"},  rvalid, 0);
        chk({tag, ".dacfin"}, dac, exp);
        step();                                   // T+18
        chk({tag, ".vld18"},  rvalid, 1);
        chk({tag, ".data"},   rdata, exp);
        chk({tag, ".ch"},     rch, c);
        chk({tag, ".busy18"}, busy, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk({tag, ".drain"},  rvalid, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            vin_tab[i]  = 8'h00;
            vin3_tab[i] = 8'h00;
        end

        // Reset
        step(2);
        chk("rst.dac",   dac, 0);
        chk("rst.mux",   msel, 0);
        chk("rst.busy",  busy, 0);
        chk("rst.vld",   rvalid, 0);
        chk("rst.data",  rdata, 0);
        chk("rst.ch",    rch, 0);
        chk("rst.busy3", busy3, 0);
        rst = 1'b0;
        step();

        // Single shot: 0xA5 on channel 2
        vin_tab[2] = 8'hA5;
        run_single("t1", 2'd2, 8'hA5, 8'h80, 8'hC0);

        // Extremes on channel 1
        vin_tab[1] = 8'h00;
        run_single("t2lo", 2'd1, 8'h00, 8'h80, 8'h40);
        vin_tab[1] = 8'hFF;
        run_single("t2hi", 2'd1, 8'hFF, 8'h80, 8'hC0);

        // Continuous scan with ready held high
        vin_tab[0] = 8'h10; vin_tab[1] = 8'h20; vin_tab[2] = 8'h30; vin_tab[3] = 8'h40;
        ready = 1'b1;
        cont  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(17);
            chk("t3.vldlow", rvalid, 0);
            step();
            chk("t3.vld",  rvalid, 1);
            chk("t3.ch",   rch, (k - 1) % 4);
            chk("t3.data", rdata, 8'h10 * (((k - 1) % 4) + 1));
        end
        cont = 1'b0;
        step();
        chk("t3.drain", rvalid, 0);
        chk("t3.idle",  busy, 0);

        // Continuous scan with backpressure. The scan pointer is now at channel 1.
        ready = 1'b0;
        cont  = 1'b1;
        step(18);                                 // U+18
        chk("t4.vld1",  rvalid, 1);
        chk("t4.data1", rdata, 8'h20);
        chk("t4.ch1",   rch, 1);
        step();                                   // U+19, second conversion running
        cont = 1'b0;
        chk("t4.busy",  busy, 1);
        chk("t4.mux",   msel, 2);
        step(21);                                 // U+40, stalled in DONE
        chk("t4.stallbusy", busy, 1);
        chk("t4.stallvld",  rvalid, 1);
        chk("t4.stalldata", rdata, 8'h20);
        chk("t4.stallch",   rch, 1);
        chk("t4.stalldac",  dac, 8'h30);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t4.swapvld",  rvalid, 1);
        chk("t4.swapdata", rdata, 8'h30);
        chk("t4.swapch",   rch, 2);
        chk("t4.swapbusy", busy, 0);
        step();
        chk("t4.holddata", rdata, 8'h30);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t4.drain", rvalid, 0);

        // Reset mid-conversion while a result is still buffered
        vin_tab[3] = 8'h77;
        start = 1'b1;
        ch    = 2'd3;
        step();
        start = 1'b0;
        step(17);
        chk("t5.bufvld",  rvalid, 1);
        chk("t5.bufdata", rdata, 8'h77);
        start = 1'b1;
        ch    = 2'd1;
        step();
        start = 1'b0;
        step(8);
        chk("t5.busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5.dac",  dac, 0);
        chk("t5.mux",  msel, 0);
        chk("t5.busy0", busy, 0);
        chk("t5.vld",  rvalid, 0);
        chk("t5.data", rdata, 0);
        chk("t5.ch",   rch, 0);
        vin_tab[1] = 8'h5A;
        run_single("t5b", 2'd1, 8'h5A, 8'h80, 8'h40);

        // Three-channel instance
        vin3_tab[0] = 8'h11; vin3_tab[1] = 8'h3C; vin3_tab[2] = 8'h99;
        start3 = 1'b1;
        ch3    = 2'd3;
        step();
        start3 = 1'b0;
        chk("t6.badbusy", busy3, 0);
        chk("t6.badmux",  msel3, 0);
        step(3);
        chk("t6.badbusy2", busy3, 0);
        chk("t6.badvld",   rvalid3, 0);
        start3 = 1'b1;
        ch3    = 2'd1;
        step();
        start3 = 1'b0;
        chk("t6.mux",  msel3, 1);
        chk("t6.busy", busy3, 1);
        step(17);
        chk("t6.vld",  rvalid3, 1);
        chk("t6.data", rdata3, 8'h3C);
        chk("t6.ch",   rch3, 1);
        ready3 = 1'b1;
        step();
        chk("t6.drain", rvalid3, 0);
        cont3 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(18);
            chk("t6.scanvld", rvalid3, 1);
            chk("t6.scanch",  rch3, (k - 1) % 3);
            chk("t6.scandata", rdata3, (((k - 1) % 3) == 0) ? 8'h11 :
                                       (((k - 1) % 3) == 1) ? 8'h3C : 8'h99);
        end
        cont3 = 1'b0;
        step(2);
        chk("t6.end", rvalid3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
